// File: rtl/usb_tx_pkg.sv
// USB TX serializer shared types.
// States, line encodings and stuffing limit.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  // Line state packed as {dp, dm}.
  typedef logic [1:0] line_t;

  localparam line_t J   = 2'b10;
  localparam line_t K   = 2'b01;
  localparam line_t SE0 = 2'b00;

  localparam int STUFF_LIMIT = 6;
  localparam int ONES_W      = $clog2(STUFF_LIMIT + 1);

  function automatic line_t level_to_line(input logic lvl);
    return lvl ? J : K;
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI level tracker and run-of-ones counter.
// Reports the next line level and when a stuff bit is due.
module usb_nrzi_stuffer
  import usb_tx_pkg::*;
#(
  parameter bit NRZI_EN  = 1'b1,
  parameter bit STUFF_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic strobe_i,
  input  logic bit_i,
  output logic level_o,
  output logic stuff_req_o
);

  logic              lvl_q, lvl_d;
  logic [ONES_W-1:0] ones_q, ones_d;

  // Line level for the bit offered now; stuff due on the 6th one.
  always_comb begin
    level_o     = NRZI_EN ? (bit_i ? lvl_q : ~lvl_q) : bit_i;
    stuff_req_o = STUFF_EN && bit_i &&
                  (ones_q == ONES_W'(STUFF_LIMIT - 1));
  end

  // Next level and ones count; clear returns the line to J.
  always_comb begin
    lvl_d  = lvl_q;
    ones_d = ones_q;
    if (clr_i) begin
      lvl_d  = 1'b1;
      ones_d = '0;
    end else if (strobe_i) begin
      lvl_d = level_o;
      if (!bit_i)
        ones_d = '0;
      else if (ones_q != ONES_W'(STUFF_LIMIT))
        ones_d = ones_q + 1'b1;
    end
  end

  // Level and ones-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= 1'b1;
      ones_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: packet shift-out with NRZI,
// bit stuffing and SE0/J end-of-packet.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int MAX_BITS     = 544,
  parameter int LEN_W        = $clog2(MAX_BITS + 1),
  parameter bit NRZI_EN      = 1'b1,
  parameter bit STUFF_EN     = 1'b1,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_en,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [MAX_BITS-1:0] load_data,
  input  logic [LEN_W-1:0]    load_len,
  input  logic                abort,
  output logic                dp_out,
  output logic                dm_out,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int EOP_W =
    (EOP_SE0_BITS < 2) ? 1 : $clog2(EOP_SE0_BITS + 1);

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [EOP_W-1:0]    eop_q, eop_d;
  logic                abort_q, abort_d;
  line_t               line_q, line_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                ready_q, ready_d;

  logic                hs;
  logic [LEN_W-1:0]    len_clamped;
  logic [EOP_W-1:0]    eop_inc;
  logic                st_bit;
  logic                st_strobe;
  logic                st_clr;
  logic                st_level;
  logic                st_stuff_req;

  assign hs          = load_valid && ready_q;
  assign len_clamped = (load_len > LEN_W'(MAX_BITS)) ?
                       LEN_W'(MAX_BITS) : load_len;
  assign eop_inc     = eop_q + 1'b1;
  assign st_bit      = (state_q == DATA) ? data_q[0] : 1'b0;

  usb_nrzi_stuffer #(
    .NRZI_EN  (NRZI_EN),
    .STUFF_EN (STUFF_EN)
  ) u_nrzi (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (st_clr),
    .strobe_i    (st_strobe),
    .bit_i       (st_bit),
    .level_o     (st_level),
    .stuff_req_o (st_stuff_req)
  );

  // Packet sequencing: load, data/stuff bits, SE0 run, final J.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    eop_d     = eop_q;
    abort_d   = abort_q;
    line_d    = line_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    st_strobe = 1'b0;
    st_clr    = 1'b0;
    // Ready drops for the done cycle, rising one edge later.
    ready_d   = (state_q == IDLE) && !hs;
    unique case (state_q)
      IDLE: begin
        line_d = J;
        if (hs) begin
          data_d  = load_data;
          rem_d   = len_clamped;
          eop_d   = '0;
          abort_d = 1'b0;
          state_d = (len_clamped == '0) ? EOP_SE0 : DATA;
        end
      end
      DATA, STUFF: begin
        if (abort) abort_d = 1'b1;
        if (bit_en && (abort || abort_q)) begin
          line_d  = SE0;
          eop_d   = EOP_W'(1);
          state_d = (EOP_SE0_BITS <= 1) ? EOP_J : EOP_SE0;
        end else if (bit_en) begin
          st_strobe = 1'b1;
          line_d    = level_to_line(st_level);
          eop_d     = '0;
          if (state_q == DATA) begin
            data_d = data_q >> 1;
            rem_d  = rem_q - 1'b1;
            if (st_stuff_req)
              state_d = STUFF;
            else if (rem_q == LEN_W'(1))
              state_d = EOP_SE0;
          end else begin
            state_d = (rem_q == '0) ? EOP_SE0 : DATA;
          end
        end
      end
      EOP_SE0: begin
        if (bit_en) begin
          line_d = SE0;
          eop_d  = eop_inc;
          if (eop_inc >= EOP_W'(EOP_SE0_BITS))
            state_d = EOP_J;
        end
      end
      EOP_J: begin
        if (bit_en) begin
          line_d    = J;
          st_clr    = 1'b1;
          done_d    = !abort_q;
          aborted_d = abort_q;
          abort_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      rem_q     <= '0;
      eop_q     <= '0;
      abort_q   <= 1'b0;
      line_q    <= J;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      eop_q     <= eop_d;
      abort_q   <= abort_d;
      line_q    <= line_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
    end
  end

  assign dp_out     = line_q[1];
  assign dm_out     = line_q[0];
  assign load_ready = ready_q;
  assign busy       = ~ready_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: NRZI and raw instances
// checked against a bit-list reference model.
module tb_usb_tx_serializer;

  localparam int MB = 544;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_en;
  logic          load_valid;
  logic [MB-1:0] load_data;
  logic [LW-1:0] load_len;
  logic          abort;

  logic ready_n, busy_n, done_n, abrt_n, dp_n, dm_n;
  logic ready_r, busy_r, done_r, abrt_r, dp_r, dm_r;

  int vecs = 0;
  int errs = 0;

  logic [1:0] exp_n[$];
  logic [1:0] exp_r[$];

  always #5 clk = ~clk;

  usb_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .load_valid (load_valid),
    .load_ready (ready_n),
    .load_data  (load_data),
    .load_len   (load_len),
    .abort      (abort),
    .dp_out     (dp_n),
    .dm_out     (dm_n),
    .busy       (busy_n),
    .done       (done_n),
    .aborted    (abrt_n)
  );

  usb_tx_serializer #(.NRZI_EN(1'b0)) dut_raw (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .load_valid (load_valid),
    .load_ready (ready_r),
    .load_data  (load_data),
    .load_len   (load_len),
    .abort      (abort),
    .dp_out     (dp_r),
    .dm_out     (dm_r),
    .busy       (busy_r),
    .done       (done_r),
    .aborted    (abrt_r)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit list, stuff after six ones, NRZI, then EOP.
  task automatic build(input logic [MB-1:0] d,
                       input int len, input int ab);
    bit   b[$];
    int   n;
    int   ones;
    logic lvl;
    exp_n.delete();
    exp_r.delete();
    n    = (len > MB) ? MB : len;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      b.push_back(d[i]);
      if (d[i]) ones++;
      else ones = 0;
      if (ones == 6) begin
        b.push_back(1'b0);
        ones = 0;
      end
    end
    if (ab >= 0)
      while (b.size() > ab) void'(b.pop_back());
    lvl = 1'b1;
    foreach (b[i]) begin
      if (!b[i]) lvl = ~lvl;
      exp_n.push_back({lvl, ~lvl});
      exp_r.push_back({b[i], ~b[i]});
    end
    repeat (2) begin
      exp_n.push_back(2'b00);
      exp_r.push_back(2'b00);
    end
    exp_n.push_back(2'b10);
    exp_r.push_back(2'b10);
  endtask

  task automatic strobe();
    @(negedge clk);
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  function automatic logic [MB-1:0] rnd_vec(input bit dense);
    logic [MB-1:0] v;
    for (int i = 0; i < MB; i += 32) begin
      logic [31:0] w;
      w = $urandom();
      if (dense) w = w | $urandom();
      for (int j = 0; j < 32; j++)
        if (i + j < MB) v[i+j] = w[j];
    end
    return v;
  endfunction

  task automatic run_pkt(input logic [MB-1:0] d, input int len,
                         input int ab, input bit hold);
    int w;
    bit last;
    build(d, len, ab);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = LW'(len);
    bit_en     = 1'($urandom_range(0, 1));
    w = 0;
    while (!ready_n && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_load", {31'b0, ready_n}, 1);
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    if (hold) load_data = ~d;
    else load_valid = 1'b0;
    check("busy_after_load", {31'b0, busy_n}, 1);
    check("ready_after_load", {31'b0, ready_r}, 0);
    for (int i = 0; i < exp_n.size(); i++) begin
      last = (i == exp_n.size() - 1);
      if (ab >= 0 && i == ab) begin
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
      end
      strobe();
      check($sformatf("line_nrzi[%0d]", i), {30'b0, dp_n, dm_n},
            {30'b0, exp_n[i]});
      check($sformatf("line_raw[%0d]", i), {30'b0, dp_r, dm_r},
            {30'b0, exp_r[i]});
      check($sformatf("done[%0d]", i), {31'b0, done_n},
            {31'b0, last && ab < 0});
      check($sformatf("aborted[%0d]", i), {31'b0, abrt_n},
            {31'b0, last && ab >= 0});
      check($sformatf("done_raw[%0d]", i), {31'b0, done_r},
            {31'b0, last && ab < 0});
      if (!last) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    load_valid = 1'b0;
    check("ready_in_done_cycle", {31'b0, ready_n}, 0);
    @(posedge clk);
    #1;
    check("ready_after_done", {31'b0, ready_n}, 1);
    check("busy_after_done", {31'b0, busy_n}, 0);
    check("done_is_pulse", {31'b0, done_n}, 0);
    check("aborted_is_pulse", {31'b0, abrt_n}, 0);
  endtask

  initial begin
    logic [MB-1:0] d;
    int len;
    rst        = 1'b1;
    bit_en     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    abort      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dp", {31'b0, dp_n}, 1);
    check("rst_dm", {31'b0, dm_n}, 0);
    check("rst_ready", {31'b0, ready_n}, 1);
    check("rst_busy", {31'b0, busy_n}, 0);
    check("rst_done", {31'b0, done_n}, 0);
    check("rst_aborted", {31'b0, abrt_n}, 0);
    rst = 1'b0;

    d = '0; d[7:0] = 8'h80;
    run_pkt(d, 8, -1, 1'b0);
    d = '0; d[7:0] = 8'hFF;
    run_pkt(d, 8, -1, 1'b0);
    d = '0; d[5:0] = 6'h3F;
    run_pkt(d, 6, -1, 1'b0);
    run_pkt(rnd_vec(1'b0), 0, -1, 1'b0);
    d = '0; d[7:0] = 8'h0F;
    run_pkt(d, 8, -1, 1'b1);
    run_pkt(rnd_vec(1'b1), 600, -1, 1'b0);
    run_pkt(rnd_vec(1'b0), 40, 4, 1'b0);

    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(0, 80);
      if (len > 0 && $urandom_range(0, 2) == 0)
        run_pkt(rnd_vec(1'(p & 1)), len,
                $urandom_range(0, len - 1), 1'(p & 2));
      else
        run_pkt(rnd_vec(1'(p & 1)), len, -1, 1'(p & 2));
    end

    d = '0; d[7:0] = 8'h55;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = LW'(8);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    repeat (3) strobe();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_line", {30'b0, dp_n, dm_n}, 32'h2);
    check("midrst_done", {31'b0, done_n}, 0);
    check("midrst_ready", {31'b0, ready_n}, 1);
    check("midrst_busy", {31'b0, busy_n}, 0);
    d = '0; d[7:0] = 8'h80;
    run_pkt(d, 8, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
